fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_sync_param.sv | 68 ++++++
 tb/tb_fifo_sync_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered level flags and sticky overflow/underflow
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] depth_c = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] af_c = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] ae_c = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, cnt_n;
  logic rd_acc, wr_acc;
  // a full FIFO still takes a write when a read frees a slot on the same edge
  always_comb begin
    rd_acc = read_enable && !empty;
    wr_acc = write_enable && (!full || rd_acc);
    cnt_n = (wr_acc && !rd_acc) ? fill_count + 1'b1 :
            (rd_acc && !wr_acc) ? fill_count - 1'b1 : fill_count;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_count <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      data_valid <= rd_acc;
      fill_count <= cnt_n;
      full <= cnt_n == depth_c;
      empty <= cnt_n == '0;
      almost_full <= cnt_n >= af_c;
      almost_empty <= cnt_n <= ae_c;
      overflow <= (write_enable && !wr_acc) || (overflow && !clear_errors);
      underflow <= (read_enable && !rd_acc) || (underflow && !clear_errors);
    end
  end
  always_ff @(posedge clk) if (reset_n && wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed tests of fifo_sync_param with default parameters
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic write_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic read_enable = 1'b0;
  logic clear_errors = 1'b0;
  logic [7:0] data_out;
  logic data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] fill_count;
  int checks = 0;
  int errors = 0;

  fifo_sync_param dut (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .data_in(data_in),
    .read_enable(read_enable), .clear_errors(clear_errors), .data_out(data_out),
    .data_valid(data_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_count(fill_count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic we, input logic [7:0] d, input logic re, input logic clr);
    write_enable = we;
    data_in = d;
    read_enable = re;
    clear_errors = clr;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    reset_n = 1'b1;
    checks++;
    if ({full, empty, almost_full, almost_empty, data_valid, overflow, underflow} !== 7'b0101000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0101000", {full, empty, almost_full, almost_empty, data_valid, overflow, underflow});
    end
    checks++;
    if (fill_count !== 3'd0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_count_data got %0d/%h exp 0/00", fill_count, data_out);
    end
  endtask

  task automatic test_fill;
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] exp_af = 4'b1100;
    logic [3:0] exp_full = 4'b1000;
    logic [3:0] exp_ae = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], 1'b0, 1'b0);
      checks++;
      if (fill_count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_count[%0d] got %0d exp %0d", i, fill_count, i + 1);
      end
      checks++;
      if ({almost_full, full, almost_empty, empty, overflow} !== {exp_af[i], exp_full[i], exp_ae[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL fill_flags[%0d] got %b exp %b", i, {almost_full, full, almost_empty, empty, overflow},
                 {exp_af[i], exp_full[i], exp_ae[i], 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_overflow_drain;
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(1'b1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fill_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set got ovf=%b cnt=%0d exp 1/4", overflow, fill_count);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== d[i] || data_valid !== 1'b1 || fill_count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain[%0d] got %h/%b/%0d exp %h/1/%0d", i, data_out, data_valid, fill_count, d[i], 3 - i);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h44 || empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold got dv=%b do=%h e=%b ovf=%b exp 0/44/1/1", data_valid, data_out, empty, overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got %b exp 0", overflow);
    end
  endtask

  task automatic test_full_simul;
    logic [7:0] d [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    step(1'b1, 8'h65, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h61 || data_valid !== 1'b1 || fill_count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_simul got do=%h dv=%b cnt=%0d f=%b ovf=%b exp 61/1/4/1/0", data_out, data_valid, fill_count, full, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== d[i] || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_simul_drain[%0d] got %h/%b exp %h/1", i, data_out, data_valid, d[i]);
      end
    end
  endtask

  task automatic test_empty_simul;
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || fill_count !== 3'd1) begin
      errors++;
      $display("FAIL empty_simul got udf=%b dv=%b cnt=%0d exp 1/0/1", underflow, data_valid, fill_count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || fill_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_simul_read got %h/%b/%0d exp a5/1/0", data_out, data_valid, fill_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear got %b exp 0", underflow);
    end
  endtask

  task automatic test_wrap;
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i + 3), 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'(i + 1) || data_valid !== 1'b1 || fill_count !== 3'd2) begin
        errors++;
        $display("FAIL wrap[%0d] got %h/%b/%0d exp %h/1/2", i, data_out, data_valid, fill_count, 8'(i + 1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'(i + 11)) begin
        errors++;
        $display("FAIL wrap_drain[%0d] got %h exp %h", i, data_out, 8'(i + 11));
      end
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_errs got ovf=%b udf=%b e=%b exp 0/0/1", overflow, underflow, empty);
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
    step(1'b1, 8'h75, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (fill_count !== 3'd3 || overflow !== 1'b1 || data_out !== 8'h71) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d ovf=%b do=%h exp 3/1/71", fill_count, overflow, data_out);
    end
    reset_n = 1'b0;
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    reset_n = 1'b1;
    checks++;
    if ({full, empty, almost_full, almost_empty, data_valid, overflow, underflow} !== 7'b0101000 ||
        fill_count !== 3'd0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got %b cnt=%0d do=%h exp 0101000/0/00",
               {full, empty, almost_full, almost_empty, data_valid, overflow, underflow}, fill_count, data_out);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || fill_count !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_read got udf=%b dv=%b cnt=%0d exp 1/0/0", underflow, data_valid, fill_count);
    end
  endtask

  task automatic test_set_wins;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got %b exp 1", underflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_after got %b exp 0", underflow);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow_drain();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_mid_reset();
    test_set_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
